// File: rtl/prio_int_ctrl.sv
// Eight-level vectored priority interrupt controller: edge-latched active-low
// requests, mask register, in-service nesting and an irq/ack/eoi handshake.
//
// state | meaning
// IDLE  | no request offered to the CPU
// PEND  | irq asserted, waiting for ack
// VECT  | vector latched, vld strobe for one cycle
module prio_int_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_,
  input  logic       ld_mask,
  input  logic [7:0] mask_in,
  input  logic       ie,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [2:0] vec,
  output logic       vld,
  output logic [3:0] level
);

  typedef enum logic [1:0] {IDLE, PEND, VECT} state_t;

  state_t     state, state_nxt;
  logic [7:0] prev_req, pend, mask, isr;
  logic [7:0] cand, edge_set, pend_nxt, isr_nxt;
  logic [3:0] w_enc, t_enc, n_enc, level_nxt;
  logic [2:0] w, t;
  logic       rc, take, irq_nxt, vld_nxt;

  // {found, index} of the highest set bit
  function automatic logic [3:0] top_bit(input logic [7:0] v);
    top_bit = 4'b0000;
    for (int k = 0; k < 8; k++)
      if (v[k]) top_bit = {1'b1, 3'(k)};
  endfunction

  always_comb begin
    cand  = pend & ~mask;
    w_enc = top_bit(cand);
    t_enc = top_bit(isr);
    w     = w_enc[2:0];
    t     = t_enc[2:0];
    rc    = ie && w_enc[3] && (!t_enc[3] || (w > t));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: if (rc) state_nxt = PEND;
      PEND: begin
        if (ack && rc) begin
          state_nxt = VECT;
          take      = 1'b1;
        end else if (!rc) begin
          state_nxt = IDLE;
        end
      end
      VECT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    irq_nxt = (state_nxt == PEND);
    vld_nxt = (state_nxt == VECT);
  end

  // A fresh edge beats the ack clear on the same bit; eoi retires before ack sets.
  always_comb begin
    edge_set = prev_req & ~req_;
    pend_nxt = (pend & ~(take ? (8'd1 << w) : 8'd0)) | edge_set;
    isr_nxt  = isr;
    if (eoi && t_enc[3]) isr_nxt[t] = 1'b0;
    if (take)            isr_nxt[w] = 1'b1;
    n_enc     = top_bit(isr_nxt);
    level_nxt = n_enc[3] ? ({1'b0, n_enc[2:0]} + 4'd1) : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_req <= 8'hFF;
      pend     <= 8'h00;
      mask     <= 8'hFF;
      isr      <= 8'h00;
      vec      <= 3'd0;
      vld      <= 1'b0;
      irq      <= 1'b0;
      level    <= 4'd0;
    end else begin
      prev_req <= req_;
      pend     <= pend_nxt;
      if (ld_mask) mask <= mask_in;
      isr      <= isr_nxt;
      if (take) vec <= w;
      vld      <= vld_nxt;
      irq      <= irq_nxt;
      level    <= level_nxt;
    end
  end

endmodule

// File: tb/tb_prio_int_ctrl.sv
// Directed bench for prio_int_ctrl: a vector table for the basic and nesting
// flows, then hand sequences for masking, hold, collisions and reset.
module tb_prio_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_;
  logic       ld_mask;
  logic [7:0] mask_in;
  logic       ie;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vec;
  logic       vld;
  logic [3:0] level;

  int nvec = 0;
  int nerr = 0;

  prio_int_ctrl dut (
    .clk(clk), .rst(rst), .req_(req_), .ld_mask(ld_mask), .mask_in(mask_in),
    .ie(ie), .ack(ack), .eoi(eoi), .irq(irq), .vec(vec), .vld(vld), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rq;
    logic       ldm;
    logic [7:0] mi;
    logic       ak;
    logic       eo;
    logic       e_irq;
    logic [2:0] e_vec;
    logic       e_vld;
    logic [3:0] e_lvl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] rq, logic ldm, logic [7:0] mi, logic ak, logic eo,
                              logic e_irq, logic [2:0] e_vec, logic e_vld, logic [3:0] e_lvl);
    vec_t v;
    v.rq = rq; v.ldm = ldm; v.mi = mi; v.ak = ak; v.eo = eo;
    v.e_irq = e_irq; v.e_vec = e_vec; v.e_vld = e_vld; v.e_lvl = e_lvl;
    return v;
  endfunction

  task automatic step(input logic [7:0] r, input logic l, input logic [7:0] m,
                      input logic a, input logic e);
    req_ = r; ld_mask = l; mask_in = m; ack = a; eoi = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int nv;
    //            req    ldm  mi     ack  eoi   irq vec  vld lvl
    tbl.push_back(mk(8'hFF, 1, 8'h00, 0, 0,   0, 0, 0, 0));   // unmask all
    tbl.push_back(mk(8'hDF, 0, 8'h00, 0, 0,   0, 0, 0, 0));   // req5 edge
    tbl.push_back(mk(8'hDF, 0, 8'h00, 0, 0,   1, 0, 0, 0));
    tbl.push_back(mk(8'hDF, 0, 8'h00, 1, 0,   0, 5, 1, 6));
    tbl.push_back(mk(8'hFF, 0, 8'h00, 0, 0,   0, 5, 0, 6));
    tbl.push_back(mk(8'hFF, 0, 8'h00, 0, 1,   0, 5, 0, 0));
    tbl.push_back(mk(8'hBB, 0, 8'h00, 0, 0,   0, 5, 0, 0));   // req2 + req6
    tbl.push_back(mk(8'hBB, 0, 8'h00, 0, 0,   1, 5, 0, 0));
    tbl.push_back(mk(8'hBB, 0, 8'h00, 1, 0,   0, 6, 1, 7));
    tbl.push_back(mk(8'hBB, 0, 8'h00, 0, 0,   0, 6, 0, 7));
    tbl.push_back(mk(8'hBB, 0, 8'h00, 0, 1,   0, 6, 0, 0));
    tbl.push_back(mk(8'hBB, 0, 8'h00, 0, 0,   1, 6, 0, 0));
    tbl.push_back(mk(8'hBB, 0, 8'h00, 1, 0,   0, 2, 1, 3));
    tbl.push_back(mk(8'hFF, 0, 8'h00, 0, 0,   0, 2, 0, 3));
    tbl.push_back(mk(8'hFF, 0, 8'h00, 0, 1,   0, 2, 0, 0));
    tbl.push_back(mk(8'hF7, 0, 8'h00, 0, 0,   0, 2, 0, 0));   // req3
    tbl.push_back(mk(8'hF7, 0, 8'h00, 0, 0,   1, 2, 0, 0));
    tbl.push_back(mk(8'hF7, 0, 8'h00, 1, 0,   0, 3, 1, 4));
    tbl.push_back(mk(8'hF5, 0, 8'h00, 0, 0,   0, 3, 0, 4));   // req1 blocked
    tbl.push_back(mk(8'hF5, 0, 8'h00, 0, 0,   0, 3, 0, 4));
    tbl.push_back(mk(8'h75, 0, 8'h00, 0, 0,   0, 3, 0, 4));   // req7 nests
    tbl.push_back(mk(8'h75, 0, 8'h00, 0, 0,   1, 3, 0, 4));
    tbl.push_back(mk(8'h75, 0, 8'h00, 1, 0,   0, 7, 1, 8));
    tbl.push_back(mk(8'h75, 0, 8'h00, 0, 0,   0, 7, 0, 8));
    tbl.push_back(mk(8'h75, 0, 8'h00, 0, 1,   0, 7, 0, 4));
    tbl.push_back(mk(8'h75, 0, 8'h00, 0, 1,   0, 7, 0, 0));
    tbl.push_back(mk(8'h75, 0, 8'h00, 0, 0,   1, 7, 0, 0));
    tbl.push_back(mk(8'h75, 0, 8'h00, 1, 0,   0, 1, 1, 2));
    tbl.push_back(mk(8'hFF, 0, 8'h00, 0, 1,   0, 1, 0, 0));

    rst = 1'b1; req_ = 8'hFF; ld_mask = 1'b0; mask_in = 8'h00;
    ie = 1'b1; ack = 1'b0; eoi = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", {irq, vec, vld, level}, 9'h000);
    chk("reset_mask", dut.mask, 8'hFF);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rq, tbl[i].ldm, tbl[i].mi, tbl[i].ak, tbl[i].eo);
      nvec++;
      if ({irq, vec, vld, level} !== {tbl[i].e_irq, tbl[i].e_vec, tbl[i].e_vld, tbl[i].e_lvl}) begin
        nerr++;
        $display("FAIL row%0d: got irq=%b vec=%0d vld=%b level=%0d expected irq=%b vec=%0d vld=%b level=%0d",
                 i, irq, vec, vld, level, tbl[i].e_irq, tbl[i].e_vec, tbl[i].e_vld, tbl[i].e_lvl);
      end
    end

    // masking
    step(8'hFF, 1, 8'h20, 0, 0);
    step(8'hDF, 0, 8'h00, 0, 0);
    chk("mask_pend5", dut.pend, 8'h20);
    step(8'hDF, 0, 8'h00, 0, 0);
    step(8'hDF, 0, 8'h00, 0, 0);
    chk("mask_no_irq", irq, 0);
    step(8'hDF, 1, 8'h00, 0, 0);
    chk("unmask_irq_late", irq, 0);
    step(8'hDF, 0, 8'h00, 0, 0);
    chk("unmask_irq", irq, 1);
    step(8'hDF, 1, 8'h20, 0, 0);
    chk("remask_irq_held", irq, 1);
    step(8'hDF, 0, 8'h00, 0, 0);
    chk("remask_irq_drop", irq, 0);
    step(8'hDF, 1, 8'h00, 0, 0);
    step(8'hDF, 0, 8'h00, 0, 0);
    step(8'hDF, 0, 8'h00, 1, 0);
    chk("mask_ack", {vec, vld, level}, {3'd5, 1'b1, 4'd6});
    step(8'hFF, 0, 8'h00, 0, 1);

    // held-low line delivers exactly one vector
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      step(8'hEF, 0, 8'h00, (i == 3), 0);
      if (vld) begin
        nv++;
        chk("hold_vec", vec, 4);
      end
    end
    chk("hold_one_vld", nv, 1);
    step(8'hFF, 0, 8'h00, 0, 0);
    chk("hold_state", {irq, level}, {1'b0, 4'd5});
    step(8'hFF, 0, 8'h00, 0, 1);
    chk("hold_eoi", level, 0);
    step(8'hFF, 0, 8'h00, 0, 1);
    chk("eoi_empty", {irq, vec, vld, level}, {1'b0, 3'd4, 1'b0, 4'd0});
    step(8'hFF, 0, 8'h00, 1, 0);
    chk("ack_idle", {irq, vec, vld, level}, {1'b0, 3'd4, 1'b0, 4'd0});

    // new edge collides with ack clear on the same bit
    step(8'hFE, 0, 8'h00, 0, 0);
    step(8'hFE, 0, 8'h00, 0, 0);
    chk("sw_irq", irq, 1);
    step(8'hFF, 0, 8'h00, 0, 0);
    step(8'hFE, 0, 8'h00, 1, 0);
    chk("sw_ack", {vec, vld, level}, {3'd0, 1'b1, 4'd1});
    chk("sw_pend_kept", dut.pend, 8'h01);
    step(8'hFE, 0, 8'h00, 0, 0);
    chk("sw_blocked", irq, 0);
    step(8'hFE, 0, 8'h00, 0, 1);
    step(8'hFE, 0, 8'h00, 0, 0);
    chk("sw_reirq", {irq, level}, {1'b1, 4'd0});
    step(8'hFE, 0, 8'h00, 1, 0);
    chk("sw_ack2", {vec, vld, level}, {3'd0, 1'b1, 4'd1});
    step(8'hFF, 0, 8'h00, 0, 1);

    // eoi and ack on the same edge
    step(8'hFB, 0, 8'h00, 0, 0);
    step(8'hFB, 0, 8'h00, 0, 0);
    step(8'hFB, 0, 8'h00, 1, 0);
    chk("ae_first", {vec, level}, {3'd2, 4'd3});
    step(8'hFF, 0, 8'h00, 0, 0);
    step(8'hBF, 0, 8'h00, 0, 0);
    step(8'hBF, 0, 8'h00, 0, 0);
    chk("ae_irq", irq, 1);
    step(8'hBF, 0, 8'h00, 1, 1);
    chk("ae_both", {vec, vld, level}, {3'd6, 1'b1, 4'd7});
    chk("ae_isr", dut.isr, 8'h40);

    // reset in the middle of a handshake
    step(8'h7E, 0, 8'h00, 0, 0);
    step(8'h7E, 0, 8'h00, 0, 0);
    chk("rst_pre", {irq, dut.pend}, {1'b1, 8'h81});
    #1 rst = 1'b1; ack = 1'b1; req_ = 8'hFF;
    #1;
    chk("rst_outputs", {irq, vec, vld, level}, 9'h000);
    chk("rst_regs", {dut.mask, dut.pend, dut.isr, dut.prev_req}, 32'hFF0000FF);
    @(posedge clk);
    #1 rst = 1'b0; ack = 1'b0;
    step(8'hFF, 0, 8'h00, 0, 0);
    chk("rst_ack_lost", {irq, vld}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
